// File: rtl/srl_word_serializer.sv
// rtl/srl_word_serializer.sv - parallel-to-serial feeder for a dynamic SRL stage
// Words are accepted on valid/ready and shifted out MSB-first with a per-word tap select.
module srl_word_serializer #(
  parameter int WIDTH    = 8,
  parameter int SELWIDTH = 5
) (
  input  logic                CLK,
  input  logic                RSTN,
  input  logic [WIDTH-1:0]    IN_DATA,
  input  logic [SELWIDTH-1:0] IN_DELAY,
  input  logic                IN_VALID,
  output logic                IN_READY,
  output logic                SI,
  output logic                CE,
  output logic [SELWIDTH-1:0] SEL,
  output logic                BUSY
);

  localparam int CNTW = $clog2(WIDTH);
  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_SHIFT = 1'b1;
  localparam logic [CNTW-1:0] CNT_LAST = CNTW'(WIDTH - 1);

  logic [0:0]          state_q, state_d;
  logic [CNTW-1:0]     cnt_q, cnt_d;
  logic [WIDTH-1:0]    shreg_q, shreg_d;
  logic [SELWIDTH-1:0] sel_q, sel_d;
  logic                last_bit;
  logic                accept;

  // Ready on the last bit lets the next word load with no bubble.
  always_comb begin
    last_bit = (state_q == ST_SHIFT) && (cnt_q == CNT_LAST);
    IN_READY = RSTN && ((state_q == ST_IDLE) || last_bit);
    accept   = IN_VALID && IN_READY;

    state_d = state_q;
    cnt_d   = cnt_q;
    shreg_d = shreg_q;
    sel_d   = sel_q;

    if (accept) begin
      state_d = ST_SHIFT;
      cnt_d   = '0;
      shreg_d = IN_DATA;
      sel_d   = IN_DELAY;
    end else if (state_q == ST_SHIFT) begin
      shreg_d = shreg_q << 1;
      if (last_bit) begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + CNTW'(1);
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      shreg_q <= '0;
      sel_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shreg_q <= shreg_d;
      sel_q   <= sel_d;
    end
  end

  assign CE   = (state_q == ST_SHIFT);
  assign SI   = CE && shreg_q[WIDTH-1];
  assign BUSY = CE;
  assign SEL  = sel_q;

endmodule

// File: tb/tb_srl_word_serializer.sv
// tb/tb_srl_word_serializer.sv - directed self-checking bench for srl_word_serializer
// Includes a 32-tap SRL reference to check the end-to-end delayed stream.
module tb_srl_word_serializer;

  logic       CLK;
  logic       RSTN;
  logic [7:0] IN_DATA;
  logic [4:0] IN_DELAY;
  logic       IN_VALID;
  logic       IN_READY;
  logic       SI;
  logic       CE;
  logic [4:0] SEL;
  logic       BUSY;

  int checks   = 0;
  int failures = 0;

  srl_word_serializer #(.WIDTH(8), .SELWIDTH(5)) dut (
    .CLK      (CLK),
    .RSTN     (RSTN),
    .IN_DATA  (IN_DATA),
    .IN_DELAY (IN_DELAY),
    .IN_VALID (IN_VALID),
    .IN_READY (IN_READY),
    .SI       (SI),
    .CE       (CE),
    .SEL      (SEL),
    .BUSY     (BUSY)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Downstream 32-tap SRL: DO follows the bit shifted in SEL+1 enables ago.
  logic [31:0] srl_q;
  logic        do_bit;
  always @(posedge CLK) begin
    if (!RSTN) srl_q <= '0;
    else if (CE) srl_q <= {srl_q[30:0], SI};
  end
  assign do_bit = srl_q[SEL];

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic e2e(input int dly, input int ncyc);
    logic [7:0] w;
    logic       exp_do;
    w = 8'hA5;
    IN_DATA  = 8'hA5;
    IN_DELAY = 5'(dly);
    IN_VALID = 1'b1;
    step();
    IN_DATA = 8'h00;
    for (int i = 0; i < ncyc; i++) begin
      if (i == ncyc - 8) IN_VALID = 1'b0;
      chk($sformatf("e2e_d%0d_ce_%0d", dly, i), 32'(CE), 32'd1);
      step();
      exp_do = (i >= dly && i - dly < 8) ? w[7 - (i - dly)] : 1'b0;
      chk($sformatf("e2e_d%0d_do_%0d", dly, i), 32'(do_bit), 32'(exp_do));
    end
    chk($sformatf("e2e_d%0d_ce_end", dly), 32'(CE), 32'd0);
  endtask

  initial begin
    logic [7:0] w;

    RSTN     = 1'b0;
    IN_VALID = 1'b1;
    IN_DATA  = 8'h5A;
    IN_DELAY = 5'd9;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rst_ready", 32'(IN_READY), 32'd0);
      chk("rst_ce",    32'(CE),       32'd0);
      chk("rst_si",    32'(SI),       32'd0);
      chk("rst_sel",   32'(SEL),      32'd0);
      chk("rst_busy",  32'(BUSY),     32'd0);
    end
    RSTN     = 1'b1;
    IN_VALID = 1'b0;
    #1;
    chk("rel_ready", 32'(IN_READY), 32'd1);

    // Single word A5, delay 3
    w        = 8'hA5;
    IN_DATA  = w;
    IN_DELAY = 5'd3;
    IN_VALID = 1'b1;
    step();
    IN_VALID = 1'b0;
    chk("single_sel", 32'(SEL), 32'd3);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("single_ce_%0d", i), 32'(CE), 32'd1);
      chk($sformatf("single_si_%0d", i), 32'(SI), 32'(w[7-i]));
      step();
    end
    chk("single_ce_end",    32'(CE),       32'd0);
    chk("single_busy_end",  32'(BUSY),     32'd0);
    chk("single_ready_end", 32'(IN_READY), 32'd1);
    chk("single_si_end",    32'(SI),       32'd0);

    // Back-to-back FF then 00 with valid held
    IN_DATA  = 8'hFF;
    IN_DELAY = 5'd1;
    IN_VALID = 1'b1;
    step();
    IN_DATA  = 8'h00;
    IN_DELAY = 5'd2;
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("b2b_ce_%0d", i), 32'(CE), 32'd1);
      chk($sformatf("b2b_si_%0d", i), 32'(SI), (i < 8) ? 32'd1 : 32'd0);
      if (i == 3) chk("b2b_ready_mid", 32'(IN_READY), 32'd0);
      if (i == 7) begin
        chk("b2b_ready_last", 32'(IN_READY), 32'd1);
        chk("b2b_sel_first",  32'(SEL),      32'd1);
      end
      if (i == 8) begin
        chk("b2b_sel_second", 32'(SEL), 32'd2);
        IN_VALID = 1'b0;
      end
      step();
    end
    chk("b2b_ce_end", 32'(CE), 32'd0);

    // IN_DELAY change without accept is ignored
    w        = 8'h3C;
    IN_DATA  = w;
    IN_DELAY = 5'd7;
    IN_VALID = 1'b1;
    step();
    IN_VALID = 1'b0;
    IN_DELAY = 5'd20;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("dly_si_%0d", i), 32'(SI), 32'(w[7-i]));
      if (i == 4) chk("dly_sel_mid", 32'(SEL), 32'd7);
      step();
    end
    chk("dly_sel_idle", 32'(SEL), 32'd7);
    step();
    step();
    chk("dly_sel_idle2", 32'(SEL), 32'd7);
    IN_DATA  = 8'h00;
    IN_VALID = 1'b1;
    step();
    IN_VALID = 1'b0;
    chk("dly_sel_new", 32'(SEL), 32'd20);
    repeat (8) step();
    chk("dly_ce_end", 32'(CE), 32'd0);

    // Reset in the middle of word C3
    w        = 8'hC3;
    IN_DATA  = w;
    IN_DELAY = 5'd9;
    IN_VALID = 1'b1;
    step();
    IN_VALID = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("mid_si_%0d", i), 32'(SI), 32'(w[7-i]));
      step();
    end
    RSTN     = 1'b0;
    IN_VALID = 1'b1;
    #1;
    chk("mid_ready_rst", 32'(IN_READY), 32'd0);
    step();
    chk("mid_ce",   32'(CE),   32'd0);
    chk("mid_si",   32'(SI),   32'd0);
    chk("mid_sel",  32'(SEL),  32'd0);
    chk("mid_busy", 32'(BUSY), 32'd0);
    RSTN     = 1'b1;
    IN_VALID = 1'b0;
    step();
    chk("mid_ce_after", 32'(CE), 32'd0);
    w        = 8'h81;
    IN_DATA  = w;
    IN_DELAY = 5'd0;
    IN_VALID = 1'b1;
    step();
    IN_VALID = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("post_ce_%0d", i), 32'(CE), 32'd1);
      chk($sformatf("post_si_%0d", i), 32'(SI), 32'(w[7-i]));
      step();
    end
    chk("post_ce_end", 32'(CE), 32'd0);

    // End-to-end through the SRL at minimum and maximum tap
    RSTN = 1'b0;
    step();
    RSTN = 1'b1;
    e2e(0, 16);
    RSTN = 1'b0;
    step();
    RSTN = 1'b1;
    e2e(31, 40);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
